palette_arbiter: RTL and testbench

Shares one 16-entry, 12-bit sprite palette between up to four pixel requesters (duck, dog, crosshair and HUD layers) in the VGA pixel pipeline. Each cycle it grants at most one lookup, returns the RGB value one cycle later with a transparency flag, and accepts palette rewrites from the game controller. Writes preempt lookups, and a single output register provides backpressure.

---
 rtl/palette_arbiter.sv | 118 +++++++++++
 tb/tb_palette_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_arbiter.sv
// Shared 16x12 sprite palette with round-robin lookup arbitration, write preemption and a registered response.
// Define PALETTE_ARB_FIXED_PRI_EN to give requester 0 absolute priority over the round-robin group.
module palette_arbiter #(
    parameter int          N_REQ   = 4,
    parameter logic [11:0] KEY_RGB = 12'hA01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_index,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [11:0]        rsp_rgb,
    output logic               rsp_transparent,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [11:0]        cfg_data
);

    logic [11:0] palette [16];
    logic [1:0]  rr_ptr;
    logic        stall;
    logic        grant_found;
    logic [1:0]  grant_id;
    logic [1:0]  next_ptr;
    logic [3:0]  grant_index;
    logic [11:0] lookup_rgb;
    int          scan_idx;

    function automatic logic [11:0] default_rgb(input logic [3:0] addr);
        case (addr)
            4'd2:       return 12'hFFF;
            4'd3:       return 12'h000;
            4'd4:       return 12'hF76;
            4'd5, 4'd6: return 12'h050;
            4'd7:       return 12'hAEA;
            default:    return 12'hA01;
        endcase
    endfunction

    // A palette write or an unconsumed response freezes the grant path.
    assign stall = cfg_we | (rsp_valid & ~rsp_ready);

    always_comb begin
        req_ready   = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        grant_index = '0;
        scan_idx    = 0;
        if (!stall) begin
`ifdef PALETTE_ARB_FIXED_PRI_EN
            if (req_valid[0]) begin
                grant_found = 1'b1;
                grant_index = req_index[3:0];
            end else begin
                // Pointer value 0 is never a group member, so it starts the scan at requester 1.
                for (int k = 0; k < N_REQ - 1; k++) begin
                    scan_idx = ((rr_ptr == 2'd0) ? 1 : int'(rr_ptr)) + k;
                    if (scan_idx >= N_REQ) scan_idx = scan_idx - (N_REQ - 1);
                    if (!grant_found && req_valid[scan_idx]) begin
                        grant_found = 1'b1;
                        grant_id    = 2'(scan_idx);
                        grant_index = req_index[4*scan_idx +: 4];
                    end
                end
            end
`else
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_id    = 2'(scan_idx);
                    grant_index = req_index[4*scan_idx +: 4];
                end
            end
`endif
            if (grant_found) req_ready[grant_id] = 1'b1;
        end
    end

    assign lookup_rgb = palette[grant_index];
    assign next_ptr   = (grant_id == 2'(N_REQ - 1)) ? 2'd0 : grant_id + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_rgb         <= '0;
            rsp_transparent <= 1'b0;
            rr_ptr          <= '0;
        end else if (grant_found) begin
            rsp_valid       <= 1'b1;
            rsp_id          <= grant_id;
            rsp_rgb         <= lookup_rgb;
            rsp_transparent <= (lookup_rgb == KEY_RGB);
`ifdef PALETTE_ARB_FIXED_PRI_EN
            if (grant_id != 2'd0) rr_ptr <= next_ptr;
`else
            rr_ptr          <= next_ptr;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Grants never coincide with writes, so a lookup can't observe a half-updated entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) palette[i] <= default_rgb(4'(i));
        end else if (cfg_we) begin
            palette[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_palette_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_index;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [11:0]   rsp_rgb;
    logic          rsp_transparent;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [11:0]   cfg_data;

    int checks = 0;
    int errors = 0;

    logic [11:0] dflt [16] = '{12'hA01, 12'hA01, 12'hFFF, 12'h000, 12'hF76, 12'h050, 12'h050, 12'hAEA,
                               12'hA01, 12'hA01, 12'hA01, 12'hA01, 12'hA01, 12'hA01, 12'hA01, 12'hA01};
    logic [11:0] m_pal [16];
    int          m_ptr;
    bit          m_valid;
    int          m_id;
    logic [11:0] m_rgb;
    bit          m_tr;

    palette_arbiter #(.N_REQ(N), .KEY_RGB(12'hA01)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rgb(rsp_rgb), .rsp_transparent(rsp_transparent),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = dflt[i];
        m_ptr = 0; m_valid = 0; m_id = 0; m_rgb = 12'h000; m_tr = 0;
    endtask

    // Which requester should win this cycle, or -1 when none.
    function automatic int exp_grant();
        int start;
        if (cfg_we || (m_valid && !rsp_ready)) return -1;
`ifdef PALETTE_ARB_FIXED_PRI_EN
        if (req_valid[0]) return 0;
        start = (m_ptr == 0) ? 1 : m_ptr;
        for (int k = 0; k < N - 1; k++) begin
            int i;
            i = 1 + (start - 1 + k) % (N - 1);
            if (req_valid[i]) return i;
        end
`else
        start = m_ptr;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_clock();
        int g;
        g = exp_grant();
        if (g >= 0) begin
            m_valid = 1;
            m_id    = g;
            m_rgb   = m_pal[req_index[4*g +: 4]];
            m_tr    = (m_rgb == 12'hA01);
`ifdef PALETTE_ARB_FIXED_PRI_EN
            if (g != 0) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        if (cfg_we) m_pal[cfg_addr] = cfg_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_index = '0; rsp_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_index = '0; rsp_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_rgb, rsp_transparent} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs actual=%h required=0", {rsp_valid, rsp_id, rsp_rgb, rsp_transparent});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0100;
        req_index = 16'h0400;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL reset_first_grant actual=%b required=0100", req_ready);
        end
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== 12'hF76 || rsp_transparent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_rsp actual=%b/%0d/%h/%b required=1/2/F76/0",
                     rsp_valid, rsp_id, rsp_rgb, rsp_transparent);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int          exp_g   [5] = '{0, 1, 2, 3, 0};
        logic [11:0] exp_rgb [5] = '{12'hFFF, 12'h000, 12'h050, 12'hAEA, 12'hFFF};
        do_reset();
        req_valid = 4'b1111;
        req_index = 16'h7532;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_g[c])) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d actual=%b required=%b", c, req_ready, 4'(1 << exp_g[c]));
            end
            model_clock();
            @(posedge clk);
            #1;
            checks++;
            if (rsp_rgb !== exp_rgb[c] || rsp_id !== 2'(exp_g[c]) || rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_rsp%0d actual=%h/%0d required=%h/%0d", c, rsp_rgb, rsp_id, exp_rgb[c], exp_g[c]);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1111;
        req_index = 16'h7532;
        model_clock();
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_ready%0d actual=%b required=0000", c, req_ready);
            end
            model_clock();
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rgb !== 12'hFFF || rsp_id !== 2'd0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d actual=%b/%h/%0d required=1/FFF/0", c, rsp_valid, rsp_rgb, rsp_id);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_resume_grant actual=%b required=0010", req_ready);
        end
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_rgb !== 12'h000 || rsp_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_resume_rsp actual=%h/%0d required=000/1", rsp_rgb, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_cfg_collision();
        do_reset();
        req_valid = 4'b0010;
        req_index = 16'h0030;
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'h0F0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL cfg_block actual=%b required=0000", req_ready);
        end
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_no_rsp actual=%b required=0", rsp_valid);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL cfg_grant actual=%b required=0010", req_ready);
        end
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_rgb !== 12'h0F0 || rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_new_value actual=%h/%0d required=0F0/1", rsp_rgb, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_transparency();
        logic [3:0] idx [4] = '{4'd0, 4'd9, 4'd15, 4'd3};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'hA01;
                model_clock();
                @(posedge clk);
                @(negedge clk);
                cfg_we = 1'b0;
            end
            req_valid = 4'b0001;
            req_index = {12'h000, idx[c]};
            model_clock();
            @(posedge clk);
            #1;
            checks++;
            if (rsp_rgb !== 12'hA01 || rsp_transparent !== 1'b1 || rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL transp_idx%0d actual=%h/%b required=A01/1", idx[c], rsp_rgb, rsp_transparent);
            end
            @(negedge clk);
            req_valid = '0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'h0F0;
        model_clock();
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        req_valid = 4'b0001;
        req_index = 16'h0003;
        model_clock();
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        model_clock();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rgb !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midreset_drop actual=%b/%h required=0/000", rsp_valid, rsp_rgb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_index = 16'h0003;
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_rgb !== 12'h000 || rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_palette actual=%h required=000", rsp_rgb);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

`ifdef PALETTE_ARB_FIXED_PRI_EN
    task automatic test_fixed_pri();
        do_reset();
        req_valid = 4'b0011;
        req_index = 16'h0032;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL fixed_pri%0d actual=%b required=0001", c, req_ready);
            end
            model_clock();
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = '0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_index = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 4'($urandom);
            cfg_data  = ($urandom_range(0, 3) == 0) ? 12'hA01 : 12'($urandom);
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready%0d actual=%b required=%b", c, req_ready, exp_ready());
            end
            model_clock();
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== m_valid ||
                (m_valid && (rsp_id !== 2'(m_id) || rsp_rgb !== m_rgb || rsp_transparent !== m_tr))) begin
                errors++;
                $display("[TB] FAIL rand_rsp%0d actual=%b/%0d/%h/%b required=%b/%0d/%h/%b", c,
                         rsp_valid, rsp_id, rsp_rgb, rsp_transparent, m_valid, m_id, m_rgb, m_tr);
            end
            @(negedge clk);
        end
        req_valid = '0;
        cfg_we = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_cfg_collision();
        test_transparency();
        test_reset_mid();
`ifdef PALETTE_ARB_FIXED_PRI_EN
        test_fixed_pri();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
